// File: rtl/serial_logic_pkg.sv
// Shared types and constants for the bit-serial logic engine.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Holds the engine FSM state encoding and the operation codes understood by
// logic_slice. The XOR/reserved codes only take effect when the slice is built
// with SERIAL_LOGIC_XOR_EN defined.
package serial_logic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

endpackage

// File: rtl/serial_logic_engine_logic_slice.sv
// 1-bit combinational logic slice: AND / OR (and XOR when enabled) into a mux.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the driver presents one bit pair per cycle.
//
// Ports:
//   a, b : operand bits
//   sel  : operation select (OP_* codes from serial_logic_pkg)
//   y    : result bit
//
// Build option: SERIAL_LOGIC_XOR_EN
//   defined   -> 00 AND, 01 OR, 10 XOR, 11 constant zero (reserved code)
//   undefined -> sel[1] is ignored; only AND/OR and a 2:1 mux exist, so
//                10 behaves as AND and 11 behaves as OR.
module logic_slice
    import serial_logic_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic [1:0] sel,
    output logic       y
);

    logic and_y;
    logic or_y;

    assign and_y = a & b;
    assign or_y  = a | b;

`ifdef SERIAL_LOGIC_XOR_EN
    logic xor_y;

    assign xor_y = a ^ b;

    always_comb begin
        y = 1'b0;
        case (sel)
            OP_AND:  y = and_y;
            OP_OR:   y = or_y;
            OP_XOR:  y = xor_y;
            default: y = 1'b0;  // reserved code produces an all-zero word
        endcase
    end
`else
    // Upper select bit has no meaning without the XOR leg.
    logic unused_sel_hi;

    assign unused_sel_hi = sel[1];
    assign y = sel[0] ? or_y : and_y;
`endif

endmodule

// File: rtl/serial_logic_engine.sv
// Bit-serial bitwise logic engine: feeds operand bit pairs LSB-first into logic_slice.
// Latency: WIDTH+1 cycles from accept to out_valid; initiation interval WIDTH+2.
// Backpressure: one job in flight; result held in DONE until out_ready, in_ready low meanwhile.
//
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (in_ready high only in IDLE)
//   a, b, op             : operands and op code, sampled only on the accept cycle
//   out_valid / out_ready: result handshake (out_valid high only in DONE)
//   f, zero              : result word and its zero flag (zero qualified by out_valid)
//   busy                 : job in progress (RUN or DONE)
//
// Build option: SERIAL_LOGIC_XOR_EN enables the XOR leg of logic_slice.
module serial_logic_engine
    import serial_logic_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             zero,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic [1:0]       op_q;
    logic [CW-1:0]    cnt;
    logic             slice_y;

    logic_slice u_slice (
        .a   (a_sh[0]),
        .b   (b_sh[0]),
        .sel (op_q),
        .y   (slice_y)
    );

    // Slice output enters at the MSB and walks down; after WIDTH shifts the
    // bit produced in step i sits at position i.
    always_comb begin
        res_next            = res >> 1;
        res_next[WIDTH-1]   = slice_y;
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            res       <= '0;
            op_q      <= OP_AND;
            cnt       <= '0;
            out_valid <= 1'b0;
            f         <= '0;
            zero      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        op_q  <= op;
                        cnt   <= '0;
                        res   <= '0;
                        state <= RUN;
                    end
                end

                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    res  <= res_next;
                    if (cnt == LAST_BIT) begin
                        // Final bit: publish the completed word directly so
                        // f and zero are valid in the same cycle as out_valid.
                        state     <= DONE;
                        out_valid <= 1'b1;
                        f         <= res_next;
                        zero      <= (res_next == '0);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        zero      <= 1'b0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
